round_sequencer: RTL

//  Top-level round scheduler for the NOT-NOT game. Sequences each round: requests a new

---
 rtl/round_sequencer_pkg.sv | 49 ++++
 rtl/round_sequencer_timer.sv | 36 +++
 rtl/round_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer_pkg
//  Description : Shared types and helpers for the NOT-NOT round scheduler:
//                FSM state encoding, instruction codes, field widths and the
//                response-window shrink function.
//  Revision    : 1.0  initial release
// ============================================================================
package round_sequencer_pkg;

   localparam int LIVES_W = 3;
   localparam int TIME_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_ARMED   = 3'd2,
      S_RELEASE = 3'd3,
      S_JUDGE   = 3'd4,
      S_RESULT  = 3'd5,
      S_OVER    = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      INSTR_UP    = 3'd0,
      INSTR_DOWN  = 3'd1,
      INSTR_LEFT  = 3'd2,
      INSTR_RIGHT = 3'd3,
      INSTR_VOWEL = 3'd4,
      INSTR_DIGIT = 3'd5
   } instr_t;

   // Subtract one step from the window with a borrow bit so an oversized step
   // cannot wrap, then clamp to the floor.
   function automatic logic [TIME_W-1:0] shrink_window(
      input logic [TIME_W-1:0] window,
      input logic [TIME_W-1:0] step,
      input logic [TIME_W-1:0] floor_val
   );
      logic [TIME_W:0] diff;
      diff = {1'b0, window} - {1'b0, step};
      if (diff[TIME_W] || (diff[TIME_W-1:0] < floor_val)) begin
         return floor_val;
      end
      return diff[TIME_W-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/round_sequencer_timer.sv
`default_nettype none
// ============================================================================
//  Module      : round_timer
//  Description : Loadable down-counter. Times the response window while a
//                round is armed and is reloaded to time the post-verdict gap.
//                'last' flags the final cycle of the loaded interval.
//  Revision    : 1.0  initial release
// ============================================================================
module round_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         enable,
   output logic         last
);

   logic [W-1:0] count;

   // Load has priority; otherwise count down while enabled, stopping at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign last = (count == W'(1));

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer
//  Description : Round scheduler for the NOT-NOT game. Requests instructions,
//                arms the response window, tracks the key press/release,
//                triggers the judge and applies verdicts to score and lives.
//  Revision    : 1.0  initial release
// ============================================================================
module round_sequencer
   import round_sequencer_pkg::*;
#(
   parameter int LIVES_INIT    = 3,
   parameter int SCORE_W       = 8,
   parameter int TIMEOUT_INIT  = 200,
   parameter int TIMEOUT_MIN   = 50,
   parameter int TIMEOUT_STEP  = 10,
   parameter int SPEEDUP_EVERY = 4,
   parameter int GAP_CYCLES    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               key_pressed,
   output logic               instr_req,
   output logic               judge_req,
   input  logic               verdict_valid,
   input  logic               verdict_correct,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [TIME_W-1:0]  time_left,
   output logic               round_active,
   output logic               game_over
);

   localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
   localparam logic [TIME_W-1:0]  WIN_INIT   = TIME_W'(TIMEOUT_INIT);
   localparam logic [TIME_W-1:0]  WIN_MIN    = TIME_W'(TIMEOUT_MIN);
   localparam logic [TIME_W-1:0]  WIN_STEP   = TIME_W'(TIMEOUT_STEP);
   localparam logic [TIME_W-1:0]  GAP_LOAD   = TIME_W'(GAP_CYCLES);
   localparam int                 SPD_W      = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
   localparam logic [SPD_W-1:0]   SPD_LAST   = SPD_W'(SPEEDUP_EVERY - 1);

   state_t             state;
   logic [TIME_W-1:0]  window;
   logic [SPD_W-1:0]   speed_cnt;

   logic               tmr_load;
   logic               tmr_enable;
   logic [TIME_W-1:0]  tmr_value;
   logic               tmr_last;

   logic [SCORE_W-1:0] score_inc;
   logic [LIVES_W-1:0] lives_dec;
   logic [TIME_W-1:0]  window_next;

   // Saturating score, non-underflowing lives and the next (clamped) window.
   always_comb begin
      score_inc   = (&score) ? score : score + SCORE_W'(1);
      lives_dec   = (lives == '0) ? '0 : lives - LIVES_W'(1);
      window_next = shrink_window(window, WIN_STEP, WIN_MIN);
   end

   // Timer control: load the window when arming, load the gap on any entry
   // into RESULT, count while armed with no key and throughout the gap.
   always_comb begin
      tmr_load   = 1'b0;
      tmr_value  = window;
      tmr_enable = 1'b0;
      case (state)
         S_ISSUE: begin
            tmr_load = !key_pressed;
         end
         S_ARMED: begin
            tmr_enable = !key_pressed;
            if (!key_pressed && tmr_last) begin
               tmr_load  = 1'b1;
               tmr_value = GAP_LOAD;
            end
         end
         S_JUDGE: begin
            if (verdict_valid) begin
               tmr_load  = 1'b1;
               tmr_value = GAP_LOAD;
            end
         end
         S_RESULT: begin
            tmr_enable = 1'b1;
         end
         default: ;
      endcase
   end

   round_timer #(
      .W (TIME_W)
   ) u_round_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (tmr_value),
      .enable     (tmr_enable),
      .last       (tmr_last)
   );

   // Round FSM with all game state and registered outputs; verdicts are
   // applied on the edge that enters RESULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         lives        <= '0;
         score        <= '0;
         time_left    <= '0;
         window       <= WIN_INIT;
         speed_cnt    <= '0;
         instr_req    <= 1'b0;
         judge_req    <= 1'b0;
         round_active <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         instr_req <= 1'b0;
         judge_req <= 1'b0;
         case (state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  state     <= S_ISSUE;
                  instr_req <= 1'b1;
                  lives     <= LIVES_LOAD;
                  score     <= '0;
                  window    <= WIN_INIT;
                  speed_cnt <= '0;
                  game_over <= 1'b0;
               end
            end
            S_ISSUE: begin
               // A key still held from the previous round must be released
               // before the window opens.
               if (!key_pressed) begin
                  state        <= S_ARMED;
                  time_left    <= window;
                  round_active <= 1'b1;
               end
            end
            S_ARMED: begin
               // A press in the expiry cycle takes precedence over the timeout.
               if (key_pressed) begin
                  state <= S_RELEASE;
               end else if (tmr_last) begin
                  state        <= S_RESULT;
                  time_left    <= '0;
                  round_active <= 1'b0;
                  lives        <= lives_dec;
               end else begin
                  time_left <= time_left - TIME_W'(1);
               end
            end
            S_RELEASE: begin
               if (!key_pressed) begin
                  state        <= S_JUDGE;
                  judge_req    <= 1'b1;
                  round_active <= 1'b0;
               end
            end
            S_JUDGE: begin
               if (verdict_valid) begin
                  state <= S_RESULT;
                  if (verdict_correct) begin
                     score <= score_inc;
                     if (speed_cnt == SPD_LAST) begin
                        speed_cnt <= '0;
                        window    <= window_next;
                     end else begin
                        speed_cnt <= speed_cnt + SPD_W'(1);
                     end
                  end else begin
                     lives <= lives_dec;
                  end
               end
            end
            S_RESULT: begin
               if (tmr_last) begin
                  if (lives == '0) begin
                     state     <= S_OVER;
                     game_over <= 1'b1;
                  end else begin
                     state     <= S_ISSUE;
                     instr_req <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
